alu_pipe: RTL and testbench

//  Parametrised, registered successor to the single-cycle ALU. Accepts one operation per

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mul_seq.sv | 45 ++++
 rtl/alu_pipe.sv | 167 ++++++++++++++++
 tb/tb_alu_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: one-hot op encodings, flag bit positions
// and boolean constants used by alu_pipe and its multiplier.
package alu_pkg;
  localparam int OP_W = 9;

  localparam int OP_ADD = 0;
  localparam int OP_AND = 1;
  localparam int OP_OR  = 2;
  localparam int OP_NOT = 3;
  localparam int OP_XOR = 4;
  localparam int OP_SL  = 5;
  localparam int OP_SR  = 6;
  localparam int OP_CMP = 7;
  localparam int OP_MUL = 8;

  localparam logic [OP_W-1:0] ALU_ADD = 9'h001;
  localparam logic [OP_W-1:0] ALU_AND = 9'h002;
  localparam logic [OP_W-1:0] ALU_OR  = 9'h004;
  localparam logic [OP_W-1:0] ALU_NOT = 9'h008;
  localparam logic [OP_W-1:0] ALU_XOR = 9'h010;
  localparam logic [OP_W-1:0] ALU_SL  = 9'h020;
  localparam logic [OP_W-1:0] ALU_SR  = 9'h040;
  localparam logic [OP_W-1:0] ALU_CMP = 9'h080;
  localparam logic [OP_W-1:0] ALU_MUL = 9'h100;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, WIDTH cycles from start to done.
// Bit 0 of B is folded in at start; the rest take WIDTH-1 steps.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               iClock,
  input  logic               iReset_n,
  input  logic               iStart,
  input  logic [WIDTH-1:0]   iA,
  input  logic [WIDTH-1:0]   iB,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oProduct
);
  localparam int SHW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;

  // Latch operands on start, then one shift-add step per cycle
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (iStart) begin
      acc    <= iB[0] ? {{WIDTH{1'b0}}, iA} : '0;
      mcand  <= {{(WIDTH-1){1'b0}}, iA, 1'b0};
      mplier <= iB >> 1;
      cnt    <= SHW'(WIDTH-1);
    end else if (cnt != '0) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end

  assign oDone    = (cnt == '0) ? TRUE : FALSE;
  assign oProduct = acc;
endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides and 1-cycle latency.
// Define ALU_MUL_EN to add the iterative multiplier (MUL op).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             iClock,
  input  logic             iReset_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iOperandA,
  input  logic [WIDTH-1:0] iOperandB,
  input  logic [OP_W-1:0]  iOperation,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oAluResult,
  output logic [3:0]       oFlags,
  output logic             oIllegal
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WV = WIDTH'(WIDTH);
`ifdef ALU_MUL_EN
  localparam logic MUL_ILL = FALSE;
`else
  localparam logic MUL_ILL = TRUE;
`endif

  logic             out_free;
  logic             accept;
  logic             is_mul;
  logic             idle;
  logic [WIDTH-1:0] res;
  logic             c_f;
  logic             v_f;
  logic             ill;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sl_t;
  logic [WIDTH:0]   sr_t;
  logic [SHW-1:0]   sh;
  logic             big;
  logic             at_w;
  logic [3:0]       flags;

  assign out_free = ~oValid | iReady;
  assign oReady   = iReset_n & idle & out_free;
  assign accept   = iValid & oReady;

  // Single-cycle result and carry/overflow for the decoded op
  always_comb begin
    sh   = iOperandB[SHW-1:0];
    big  = (iOperandB >= WV);
    at_w = (iOperandB == WV);
    sum  = {1'b0, iOperandA} + {1'b0, iOperandB};
    sl_t = {1'b0, iOperandA} << sh;
    sr_t = {iOperandA, 1'b0} >> sh;
    res  = '0;
    c_f  = FALSE;
    v_f  = FALSE;
    ill  = FALSE;
    if (!$onehot(iOperation)) begin
      ill = TRUE;
    end else begin
      unique case (1'b1)
        iOperation[OP_ADD]: begin
          res = sum[WIDTH-1:0];
          c_f = sum[WIDTH];
          v_f = (iOperandA[WIDTH-1] == iOperandB[WIDTH-1])
              & (sum[WIDTH-1] != iOperandA[WIDTH-1]);
        end
        iOperation[OP_AND]: res = iOperandA & iOperandB;
        iOperation[OP_OR]:  res = iOperandA | iOperandB;
        iOperation[OP_NOT]: res = ~iOperandA;
        iOperation[OP_XOR]: res = iOperandA ^ iOperandB;
        iOperation[OP_SL]: begin
          res = big ? '0 : sl_t[WIDTH-1:0];
          c_f = big ? (at_w & iOperandA[0]) : sl_t[WIDTH];
        end
        iOperation[OP_SR]: begin
          res = big ? '0 : sr_t[WIDTH:1];
          c_f = big ? (at_w & iOperandA[WIDTH-1]) : sr_t[0];
        end
        iOperation[OP_CMP]: begin
          res = {{(WIDTH-1){1'b0}}, iOperandA == iOperandB};
          c_f = iOperandA < iOperandB;
        end
        iOperation[OP_MUL]: ill = MUL_ILL;
        default: ill = TRUE;
      endcase
    end
  end

  // Pack {N,V,C,Z} for the single-cycle path
  always_comb begin
    flags         = '0;
    flags[FLAG_N] = res[WIDTH-1];
    flags[FLAG_V] = v_f;
    flags[FLAG_C] = c_f;
    flags[FLAG_Z] = (res == '0);
  end

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state;
  logic               mul_done;
  logic               mul_fire;
  logic [2*WIDTH-1:0] prod;
  logic [3:0]         mflags;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .iClock   (iClock),
    .iReset_n (iReset_n),
    .iStart   (accept & is_mul),
    .iA       (iOperandA),
    .iB       (iOperandB),
    .oDone    (mul_done),
    .oProduct (prod)
  );

  assign idle     = (state == S_IDLE);
  assign is_mul   = (iOperation == ALU_MUL);
  assign mul_fire = ~idle & mul_done & out_free;

  // Flags for the low half of the product; C marks high-half overflow
  always_comb begin
    mflags         = '0;
    mflags[FLAG_N] = prod[WIDTH-1];
    mflags[FLAG_C] = |prod[2*WIDTH-1:WIDTH];
    mflags[FLAG_Z] = (prod[WIDTH-1:0] == '0);
  end
`else
  assign idle   = TRUE;
  assign is_mul = FALSE;
`endif

  // Output register, handshake drain and multiplier FSM
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      oValid     <= FALSE;
      oAluResult <= '0;
      oFlags     <= '0;
      oIllegal   <= FALSE;
`ifdef ALU_MUL_EN
      state      <= S_IDLE;
`endif
    end else begin
      if (oValid && iReady) oValid <= FALSE;
      if (accept && !is_mul) begin
        oValid     <= TRUE;
        oAluResult <= res;
        oFlags     <= flags;
        oIllegal   <= ill;
      end
`ifdef ALU_MUL_EN
      if (accept && is_mul) state <= S_MUL;
      if (mul_fire) begin
        oValid     <= TRUE;
        oAluResult <= prod[WIDTH-1:0];
        oFlags     <= mflags;
        oIllegal   <= FALSE;
        state      <= S_IDLE;
      end
`endif
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=16); honours ALU_MUL_EN.
// Driver pushes expected results, monitor pops on output handshake.
module tb_alu_pipe;
  localparam int W = 16;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         iClock = 1'b0;
  logic         iReset_n;
  logic         iValid;
  logic         oReady;
  logic [W-1:0] iOperandA;
  logic [W-1:0] iOperandB;
  logic [8:0]   iOperation;
  logic         oValid;
  logic         iReady;
  logic [W-1:0] oAluResult;
  logic [3:0]   oFlags;
  logic         oIllegal;

  int n_checks = 0;
  int n_fail   = 0;
  int stall    = 0;
  bit rnd_rdy  = 1'b0;
  logic [20:0] sb_q[$];

  alu_pipe #(.WIDTH(W)) dut (
    .iClock     (iClock),
    .iReset_n   (iReset_n),
    .iValid     (iValid),
    .oReady     (oReady),
    .iOperandA  (iOperandA),
    .iOperandB  (iOperandB),
    .iOperation (iOperation),
    .oValid     (oValid),
    .iReady     (iReady),
    .oAluResult (oAluResult),
    .oFlags     (oFlags),
    .oIllegal   (oIllegal)
  );

  always #5 iClock = ~iClock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {illegal, N,V,C,Z, result} from plain integer arithmetic
  function automatic logic [20:0] model(input logic [W-1:0] a_in,
                                        input logic [W-1:0] b_in,
                                        input logic [8:0] op);
    longint unsigned a, b, r, p;
    longint sa, sb, ss;
    bit c, v;
    a = a_in; b = b_in; r = 0; c = 0; v = 0;
    if ($countones(op) != 1 || (op == 9'h100 && !MUL_EN))
      return {1'b1, 4'b0001, 16'h0000};
    if (op == 9'h001) begin
      p = a + b; r = p % 65536; c = (p >= 65536);
      sa = (a >= 32768) ? longint'(a) - 65536 : longint'(a);
      sb = (b >= 32768) ? longint'(b) - 65536 : longint'(b);
      ss = sa + sb; v = (ss > 32767) || (ss < -32768);
    end else if (op == 9'h002) r = a & b;
    else if (op == 9'h004) r = a | b;
    else if (op == 9'h008) r = 65535 - a;
    else if (op == 9'h010) r = a ^ b;
    else if (op == 9'h020) begin
      r = (b >= 16) ? 0 : (a << b) % 65536;
      c = (b == 0 || b > 16) ? 0 : ((a >> (16 - b)) & 1);
    end else if (op == 9'h040) begin
      r = (b >= 16) ? 0 : (a >> b);
      c = (b == 0 || b > 16) ? 0 : ((a >> (b - 1)) & 1);
    end else if (op == 9'h080) begin
      r = (a == b) ? 1 : 0; c = (a < b);
    end else begin
      p = a * b; r = p % 65536; c = (p / 65536) != 0;
    end
    return {1'b0, r >= 32768, v, c, r == 0, 16'(r)};
  endfunction

  task automatic step_ready();
    if (stall > 0) begin
      iReady = 1'b0; stall--;
    end else if (rnd_rdy) iReady = ($urandom_range(3) != 0);
    else iReady = 1'b1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [8:0] op, input logic [20:0] exp);
    bit acc = 1'b0;
    int t = 0;
    while (!acc && t < 300) begin
      @(negedge iClock);
      step_ready();
      iValid = 1'b1; iOperandA = a; iOperandB = b; iOperation = op;
      #1;
      if (oReady) begin
        acc = 1'b1;
        sb_q.push_back(exp);
      end
      t++;
    end
    chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iClock);
      step_ready();
      iValid = 1'b0;
      #1;
    end
  endtask

  task automatic issue_m(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [8:0] op);
    issue(a, b, op, model(a, b, op));
  endtask

  // Monitor: pop on every output handshake, check held data is stable
  initial begin : monitor
    logic [20:0] held;
    logic [20:0] got;
    bit hv;
    hv = 1'b0; held = '0;
    forever begin
      @(negedge iClock);
      #2;
      got = {oIllegal, oFlags, oAluResult};
      if (!iReset_n) begin
        hv = 1'b0;
      end else begin
        if (oValid && !iReady) begin
          chk("ready_low_on_hold", 32'(oReady), 32'd0);
          if (hv) chk("held_stable", 32'(got), 32'(held));
          held = got; hv = 1'b1;
        end else hv = 1'b0;
        if (oValid && iReady) begin
          if (sb_q.size() == 0) chk("unexpected_output", 32'(got), 32'hFFFF_FFFF);
          else chk("scoreboard", 32'(got), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  initial begin : driver
    int k, cnt;
    logic [W-1:0] a, b;
    logic [8:0] op;
    iReset_n = 1'b0; iValid = 1'b0; iReady = 1'b1;
    iOperandA = '0; iOperandB = '0; iOperation = '0;
    #12;
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_result", 32'(oAluResult), 32'd0);
    chk("rst_flags", 32'(oFlags), 32'd0);
    chk("rst_illegal", 32'(oIllegal), 32'd0);
    chk("rst_ready", 32'(oReady), 32'd0);
    @(negedge iClock);
    iReset_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(oReady), 32'd1);

    issue(16'hFFFF, 16'h0001, 9'h001, {1'b0, 4'b0011, 16'h0000});
    issue(16'h7FFF, 16'h0001, 9'h001, {1'b0, 4'b1100, 16'h8000});
    issue(16'h8001, 16'h0001, 9'h020, {1'b0, 4'b0010, 16'h0002});
    issue(16'h0001, 16'd16,   9'h040, {1'b0, 4'b0001, 16'h0000});
    issue(16'h1234, 16'h5678, 9'h003, {1'b1, 4'b0001, 16'h0000});
    issue(16'h1234, 16'h5678, 9'h000, {1'b1, 4'b0001, 16'h0000});
    issue(16'h1234, 16'h1234, 9'h080, {1'b0, 4'b0000, 16'h0001});
    issue(16'h0003, 16'h0005, 9'h080, {1'b0, 4'b0011, 16'h0000});
    issue(16'hF0F0, 16'h0000, 9'h008, {1'b0, 4'b0000, 16'h0F0F});

    issue_m(16'hAAAA, 16'h0F0F, 9'h010);
    issue_m(16'h1111, 16'h1111, 9'h010);
    stall = 3;
    issue_m(16'h8000, 16'h0001, 9'h010);
    issue_m(16'h00FF, 16'hFF00, 9'h010);
    idle(2);

    issue(16'h0100, 16'h0100, 9'h100,
          MUL_EN ? {1'b0, 4'b0011, 16'h0000} : {1'b1, 4'b0001, 16'h0000});
`ifdef ALU_MUL_EN
    cnt = 0;
    k = 0;
    do begin
      @(negedge iClock);
      iValid = 1'b0; iReady = 1'b1;
      #1;
      if (!oReady) cnt++;
      k++;
    end while (!oReady && k < 100);
    chk("mul_busy_cycles", 32'(cnt), 32'd16);
    chk("mul_valid_at_exit", 32'(oValid), 32'd1);
    idle(2);
    issue_m(16'h0123, 16'h0456, 9'h100);
    idle(5);
    @(negedge iClock);
    iReset_n = 1'b0;
    #1;
    chk("mid_mul_rst_valid", 32'(oValid), 32'd0);
    chk("mid_mul_rst_ready", 32'(oReady), 32'd0);
    sb_q.delete();
    repeat (2) @(negedge iClock);
    iReset_n = 1'b1;
    #1;
    chk("ready_after_mul_rst", 32'(oReady), 32'd1);
    issue_m(16'h0005, 16'h0007, 9'h001);
`endif

    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(9);
      op = 9'd1 << k;
      if (k == 9) op = 9'($urandom);
      a = 16'($urandom);
      b = ($urandom_range(2) == 0) ? 16'($urandom_range(20)) : 16'($urandom);
      if ($urandom_range(4) == 0) idle(1);
      issue_m(a, b, op);
    end
    rnd_rdy = 1'b0;
    k = 0;
    do begin
      idle(1);
      k++;
    end while ((sb_q.size() != 0 || oValid) && k < 2000);
    chk("drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
